// File: rtl/ysyx_22050612_rf_wb_arbiter.sv
// Register-file writeback arbiter: EXU (port 0) and LSU (port 1) share one RF write port.
// Round-robin grant, one registered write stage, x0 writes dropped, forwarding of the
// in-flight write to the decoder read indices.
// Optional macro RF_WB_PERF_CNT_EN adds saturating conflict/stall counters.
module ysyx_22050612_rf_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  fwd1_hit,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd2_data
`ifdef RF_WB_PERF_CNT_EN
  ,
  output logic [31:0]           conflict_cnt,
  output logic [31:0]           stall0_cnt,
  output logic [31:0]           stall1_cnt
`endif
);

  // rr_q names the port that wins the next conflict (0 = EXU)
  logic                  rr_q, rr_d;
  logic                  grant0, grant1;
  logic                  wen_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // Round-robin grant; gated by rst_n so nothing is accepted while reset is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      grant0 = req0_valid & (~req1_valid | ~rr_q);
      grant1 = req1_valid & (~req0_valid |  rr_q);
    end
    req0_ready = grant0;
    req1_ready = grant1;
  end

  // Next pointer and next write stage contents
  always_comb begin
    rr_d    = rr_q;
    wen_d   = 1'b0;
    waddr_d = rf_waddr;
    wdata_d = rf_wdata;
    if (grant0) begin
      rr_d = 1'b1;
      if (req0_addr != '0) begin
        wen_d   = 1'b1;
        waddr_d = req0_addr;
        wdata_d = req0_data;
      end
    end else if (grant1) begin
      rr_d = 1'b0;
      if (req1_addr != '0) begin
        wen_d   = 1'b1;
        waddr_d = req1_addr;
        wdata_d = req1_data;
      end
    end
  end

  // Pointer and registered write stage; reset discards any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rr_q     <= rr_d;
      rf_wen   <= wen_d;
      rf_waddr <= waddr_d;
      rf_wdata <= wdata_d;
    end
  end

  // Forward the write currently presented to the RF; x0 never forwards
  always_comb begin
    fwd1_hit  = rf_wen & (rs1 == rf_waddr) & (rs1 != '0);
    fwd2_hit  = rf_wen & (rs2 == rf_waddr) & (rs2 != '0);
    fwd1_data = rf_wdata;
    fwd2_data = rf_wdata;
  end

`ifdef RF_WB_PERF_CNT_EN
  logic [31:0] conflict_d, stall0_d, stall1_d;

  // Saturating increments of the performance counters
  always_comb begin
    conflict_d = conflict_cnt;
    stall0_d   = stall0_cnt;
    stall1_d   = stall1_cnt;
    if (req0_valid && req1_valid && conflict_cnt != 32'hFFFF_FFFF) begin
      conflict_d = conflict_cnt + 32'd1;
    end
    if (req0_valid && !req0_ready && stall0_cnt != 32'hFFFF_FFFF) begin
      stall0_d = stall0_cnt + 32'd1;
    end
    if (req1_valid && !req1_ready && stall1_cnt != 32'hFFFF_FFFF) begin
      stall1_d = stall1_cnt + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      stall0_cnt   <= '0;
      stall1_cnt   <= '0;
    end else begin
      conflict_cnt <= conflict_d;
      stall0_cnt   <= stall0_d;
      stall1_cnt   <= stall1_d;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050612_rf_wb_arbiter.sv
// Directed, table-driven bench for ysyx_22050612_rf_wb_arbiter.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_ysyx_22050612_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr, rf_waddr, rs1, rs2;
  logic [63:0] req0_data, req1_data, rf_wdata, fwd1_data, fwd2_data;
  logic        rf_wen, fwd1_hit, fwd2_hit;
`ifdef RF_WB_PERF_CNT_EN
  logic [31:0] conflict_cnt, stall0_cnt, stall1_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ysyx_22050612_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rs1        (rs1),
    .rs2        (rs2),
    .fwd1_hit   (fwd1_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_hit   (fwd2_hit),
    .fwd2_data  (fwd2_data)
`ifdef RF_WB_PERF_CNT_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall0_cnt   (stall0_cnt),
    .stall1_cnt   (stall1_cnt)
`endif
  );

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [63:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [63:0] d1;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_r0;
    logic        e_r1;
    logic        e_wen;
    logic        chk_wr;  // compare rf_waddr/rf_wdata/fwd data
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic        e_f1;
    logic        e_f2;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    rs1 = v.rs1; rs2 = v.rs2;
  endtask

  function automatic vec_t mk(logic v0, logic [4:0] a0, logic [63:0] d0,
                              logic v1, logic [4:0] a1, logic [63:0] d1,
                              logic [4:0] r1, logic [4:0] r2,
                              logic er0, logic er1, logic ewen, logic chk,
                              logic [4:0] ea, logic [63:0] ed, logic ef1, logic ef2);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.rs1 = r1; v.rs2 = r2; v.e_r0 = er0; v.e_r1 = er1; v.e_wen = ewen;
    v.chk_wr = chk; v.e_addr = ea; v.e_data = ed; v.e_f1 = ef1; v.e_f2 = ef2;
    return v;
  endfunction

  initial begin
    // v0 a0 d0 | v1 a1 d1 | rs1 rs2 | r0 r1 wen chk addr data | f1 f2
    vecs[0]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0,     0, 0);
    vecs[1]  = mk(1, 5, 'hA5,  0, 0, 0,     0, 0, 1, 0, 0, 1, 0, 0,     0, 0);
    vecs[2]  = mk(0, 0, 0,     0, 0, 0,     5, 8, 0, 0, 1, 1, 5, 'hA5,  1, 0);
    vecs[3]  = mk(0, 0, 0,     1, 3, 'h33,  5, 0, 0, 1, 0, 1, 5, 'hA5,  0, 0);
    vecs[4]  = mk(1, 1, 'h11,  1, 2, 'h22,  3, 0, 1, 0, 1, 1, 3, 'h33,  1, 0);
    vecs[5]  = mk(1, 1, 'h11,  1, 2, 'h22,  0, 1, 0, 1, 1, 1, 1, 'h11,  0, 1);
    vecs[6]  = mk(1, 1, 'h11,  1, 2, 'h22,  2, 0, 1, 0, 1, 1, 2, 'h22,  1, 0);
    vecs[7]  = mk(1, 1, 'h11,  1, 2, 'h22,  0, 0, 0, 1, 1, 1, 1, 'h11,  0, 0);
    vecs[8]  = mk(0, 0, 0,     1, 0, 'hFF,  0, 0, 0, 1, 1, 1, 2, 'h22,  0, 0);
    vecs[9]  = mk(0, 0, 0,     0, 0, 0,     0, 2, 0, 0, 0, 0, 0, 0,     0, 0);
    vecs[10] = mk(1, 7, 'h1234, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 0,     0, 0);
    vecs[11] = mk(0, 0, 0,     0, 0, 0,     7, 8, 0, 0, 1, 1, 7, 'h1234, 1, 0);
    vecs[12] = mk(0, 0, 0,     0, 0, 0,     8, 7, 0, 0, 0, 1, 7, 'h1234, 0, 0);
    vecs[13] = mk(1, 9, 'hAA,  1, 9, 'hBB,  0, 0, 0, 1, 0, 1, 7, 'h1234, 0, 0);
    vecs[14] = mk(1, 9, 'hAA,  0, 0, 0,     9, 0, 1, 0, 1, 1, 9, 'hBB,  1, 0);
    vecs[15] = mk(0, 0, 0,     0, 0, 0,     9, 0, 0, 0, 1, 1, 9, 'hAA,  1, 0);

    rst_n = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d req0_ready", i), 64'(req0_ready), 64'(vecs[i].e_r0));
      check($sformatf("v%0d req1_ready", i), 64'(req1_ready), 64'(vecs[i].e_r1));
      check($sformatf("v%0d rf_wen", i), 64'(rf_wen), 64'(vecs[i].e_wen));
      check($sformatf("v%0d fwd1_hit", i), 64'(fwd1_hit), 64'(vecs[i].e_f1));
      check($sformatf("v%0d fwd2_hit", i), 64'(fwd2_hit), 64'(vecs[i].e_f2));
      if (vecs[i].chk_wr) begin
        check($sformatf("v%0d rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].e_addr));
        check($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].e_data);
        check($sformatf("v%0d fwd1_data", i), fwd1_data, vecs[i].e_data);
        check($sformatf("v%0d fwd2_data", i), fwd2_data, vecs[i].e_data);
      end
    end

`ifdef RF_WB_PERF_CNT_EN
    @(negedge clk);
    check("conflict_cnt", 64'(conflict_cnt), 64'd5);
    check("stall0_cnt", 64'(stall0_cnt), 64'd3);
    check("stall1_cnt", 64'(stall1_cnt), 64'd2);
`endif

    // Reset mid-stream while req0 is being granted
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 64'h44;
    req1_valid = 1'b0; rs1 = 5'd4; rs2 = 5'd0;
    #1;
    check("rst pre req0_ready", 64'(req0_ready), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst req0_ready", 64'(req0_ready), 64'd0);
    check("rst rf_wen", 64'(rf_wen), 64'd0);
    @(posedge clk);
    #1;
    check("rst post-edge rf_wen", 64'(rf_wen), 64'd0);
    check("rst rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst rf_wdata", rf_wdata, 64'd0);
    check("rst fwd1_hit", 64'(fwd1_hit), 64'd0);
`ifdef RF_WB_PERF_CNT_EN
    check("rst conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif

    // After release, a conflict goes to port 0 first
    @(negedge clk);
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 64'h66;
    #1;
    check("post-rst req0_ready", 64'(req0_ready), 64'd1);
    check("post-rst req1_ready", 64'(req1_ready), 64'd0);
    @(negedge clk);
    #1;
    check("post-rst rf_waddr", 64'(rf_waddr), 64'd4);
    check("post-rst req1_ready", 64'(req1_ready), 64'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
